// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with a pixel-request stage that runs
// PIX_LAT pixel ticks ahead of the sync/blank/RGB outputs to the video DAC.
module vga_timing_gen_param #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned COLOR_W = 10,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned V_FP    = 10,
  parameter bit          H_POL   = 1'b0,
  parameter bit          V_POL   = 1'b0,
  parameter int unsigned PIX_LAT = 2,
  parameter int unsigned CNT_W   = 10
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Enable,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oReq,
  output logic [CNT_W-1:0]   oCoord_X,
  output logic [CNT_W-1:0]   oCoord_Y,
  output logic               oLine_Start,
  output logic               oFrame_Start,
  output logic               oPix_Tick,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_ACT_S = H_SYNC + H_BP;
  localparam int unsigned H_ACT_E = H_ACT_S + H_ACT;
  localparam int unsigned V_ACT_S = V_SYNC + V_BP;
  localparam int unsigned V_ACT_E = V_ACT_S + V_ACT;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned F_HS    = 2;
  localparam int unsigned F_VS    = 1;
  localparam int unsigned F_ACT   = 0;

  if (CLK_DIV < 1 || PIX_LAT < 1 ||
      64'(H_TOTAL - 1) >= (64'd1 << CNT_W) ||
      64'(V_TOTAL - 1) >= (64'd1 << CNT_W)) begin : g_param_check
    $error("vga_timing_gen_param: illegal parameter set");
  end

  logic [DIV_W-1:0]          div_cnt;
  logic [CNT_W-1:0]          h_cnt;
  logic [CNT_W-1:0]          v_cnt;
  logic [PIX_LAT-1:0][2:0]   dly;
  logic [2:0]                tail_c;
  logic                      tick_c;
  logic                      h_wrap_c;
  logic                      v_wrap_c;
  logic                      hsync_c;
  logic                      vsync_c;
  logic                      act_c;

  assign tick_c   = Enable && (32'(div_cnt) == CLK_DIV - 1);
  assign h_wrap_c = (32'(h_cnt) == H_TOTAL - 1);
  assign v_wrap_c = (32'(v_cnt) == V_TOTAL - 1);
  assign hsync_c  = (32'(h_cnt) < H_SYNC);
  assign vsync_c  = (32'(v_cnt) < V_SYNC);
  assign act_c    = (32'(h_cnt) >= H_ACT_S) && (32'(h_cnt) < H_ACT_E) &&
                    (32'(v_cnt) >= V_ACT_S) && (32'(v_cnt) < V_ACT_E);
  assign tail_c   = dly[PIX_LAT-1];

  assign oVGA_SYNC  = 1'b0;
  assign oVGA_CLOCK = Clock;

  // Pixel-tick divider and raster counters
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!Enable) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) begin
        h_cnt <= h_wrap_c ? '0 : h_cnt + CNT_W'(1);
        if (h_wrap_c) v_cnt <= v_wrap_c ? '0 : v_cnt + CNT_W'(1);
      end
    end
  end

  // Request stage: strobes last one Clock cycle, coordinates hold between ticks
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      oReq         <= 1'b0;
      oCoord_X     <= '0;
      oCoord_Y     <= '0;
      oLine_Start  <= 1'b0;
      oFrame_Start <= 1'b0;
      oPix_Tick    <= 1'b0;
    end else if (!Enable) begin
      oReq         <= 1'b0;
      oCoord_X     <= '0;
      oCoord_Y     <= '0;
      oLine_Start  <= 1'b0;
      oFrame_Start <= 1'b0;
      oPix_Tick    <= 1'b0;
    end else begin
      oReq         <= 1'b0;
      oLine_Start  <= 1'b0;
      oFrame_Start <= 1'b0;
      oPix_Tick    <= tick_c;
      if (tick_c) begin
        oReq         <= act_c;
        oCoord_X     <= act_c ? h_cnt - CNT_W'(H_ACT_S) : '0;
        oCoord_Y     <= act_c ? v_cnt - CNT_W'(V_ACT_S) : '0;
        oLine_Start  <= (h_cnt == '0);
        oFrame_Start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

  // Flag delay line aligning sync/blank with the pixel source latency
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dly <= '0;
    end else if (!Enable) begin
      dly <= '0;
    end else if (tick_c) begin
      for (int i = int'(PIX_LAT) - 1; i > 0; i--) dly[i] <= dly[i-1];
      dly[0] <= {hsync_c, vsync_c, act_c};
    end
  end

  // Display stage driving the DAC
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      oVGA_H_SYNC <= ~H_POL;
      oVGA_V_SYNC <= ~V_POL;
      oVGA_BLANK  <= 1'b0;
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
    end else if (!Enable) begin
      oVGA_H_SYNC <= ~H_POL;
      oVGA_V_SYNC <= ~V_POL;
      oVGA_BLANK  <= 1'b0;
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
    end else if (tick_c) begin
      oVGA_H_SYNC <= tail_c[F_HS] ? H_POL : ~H_POL;
      oVGA_V_SYNC <= tail_c[F_VS] ? V_POL : ~V_POL;
      oVGA_BLANK  <= tail_c[F_ACT];
      oVGA_R      <= tail_c[F_ACT] ? iRed   : '0;
      oVGA_G      <= tail_c[F_ACT] ? iGreen : '0;
      oVGA_B      <= tail_c[F_ACT] ? iBlue  : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
Parametrised VGA timing and pixel-pipeline controller. Successor to the fixed 640x480 controller. Timing, pixel-clock divide, sync polarity and colour width are all configurable. Issues pixel requests (coordinates) PIX_LAT pixel ticks ahead of display, so pipelined pixel sources (frame-buffer SRAM, sprite engines) line up exactly with sync and blank. Sits between the pixel generator and the off-chip video DAC.

Parameters:
CLK_DIV, 2, Clock cycles per pixel tick (>=1)
COLOR_W, 10, bits per colour channel
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch
V_ACT, 480, active lines
V_FP, 10, vertical front porch
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
PIX_LAT, 2, pixel-source latency in pixel ticks (>=1)
CNT_W, 10, counter and coordinate width

Ports:
Clock  in  1  system clock
Resetn  in  1  asynchronous active-low reset
Enable  in  1  run; low = hold timing in reset state (synchronous)
iRed  in  COLOR_W  red for the pixel requested PIX_LAT ticks earlier
iGreen  in  COLOR_W  green, same timing
iBlue  in  COLOR_W  blue, same timing
oReq  out  1  pixel request, active region only, high for one Clock cycle per tick
oCoord_X  out  CNT_W  requested X, 0..H_ACT-1
oCoord_Y  out  CNT_W  requested Y, 0..V_ACT-1
oLine_Start  out  1  one-cycle pulse on the tick where H_Cont=0
oFrame_Start  out  1  one-cycle pulse on the tick where H_Cont=0 and V_Cont=0
oPix_Tick  out  1  pixel-tick strobe (DAC clock enable)
oVGA_R  out  COLOR_W  red to DAC
oVGA_G  out  COLOR_W  green to DAC
oVGA_B  out  COLOR_W  blue to DAC
oVGA_H_SYNC  out  1  hsync
oVGA_V_SYNC  out  1  vsync
oVGA_BLANK  out  1  high = active display (DAC BLANK_N)
oVGA_SYNC  out  1  constant 0
oVGA_CLOCK  out  1  equals Clock

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP.
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds CNT_W bits, CLK_DIV<1 or PIX_LAT<1.
- Tick divider counts 0..CLK_DIV-1. A tick is the cycle where the count equals CLK_DIV-1. CLK_DIV=1 gives a tick every cycle. oPix_Tick is the registered tick.
- H_Cont counts 0..H_TOTAL-1 and wraps on ticks. V_Cont advances on the tick where H_Cont wraps, and itself wraps at V_TOTAL-1.
- Line layout: sync, back porch, active, front porch.
  - Sync region: H_Cont < H_SYNC.
  - Active: H_SYNC+H_BP <= H_Cont < H_SYNC+H_BP+H_ACT. Vertical is analogous.
- Request stage, registered and updated each tick from the current counters:
  - oReq = hactive & vactive.
  - oCoord_X = H_Cont-(H_SYNC+H_BP) and oCoord_Y = V_Cont-(V_SYNC+V_BP) when oReq; otherwise 0.
  - oLine_Start and oFrame_Start are also registered here.
- Display stage:
  - hsync, vsync and active flags pass through a PIX_LAT-deep, tick-enabled delay line.
  - On each tick, the outputs take the delay-line tail:
    - oVGA_H_SYNC = H_POL if in sync region, else ~H_POL (V likewise).
    - oVGA_BLANK = active.
    - oVGA_R/G/B = active ? iRed/iGreen/iBlue : 0.
- Latency: the display outputs for a pixel update exactly PIX_LAT ticks after the tick that set its oReq/oCoord. The source must hold iRGB valid at that tick. iRGB is sampled only on ticks.
- All outputs hold between ticks, except oReq, oLine_Start and oFrame_Start, which are high for one Clock cycle per tick.
- Reset values:
  - Divider, counters and delay line are 0.
  - oReq, oCoord, oLine_Start, oFrame_Start, oPix_Tick, RGB and oVGA_BLANK are 0.
  - oVGA_H_SYNC = ~H_POL and oVGA_V_SYNC = ~V_POL (inactive).
- Enable low:
  - On the next Clock edge the divider, counters and delay line return to their reset values, and all outputs go to their reset values.
  - When Enable returns high, the first tick gives oFrame_Start=1 with the counters at (0,0).
- Reset asserted mid-frame: immediate asynchronous return to the reset values. Counting restarts from (0,0), with no partial-line recovery.
- Wrap: the last pixel of the last line is followed directly by (0,0). There is no extra idle tick.

Test Plan:
- Default params, Enable=1:
  - H period = 1600 Clock cycles; oVGA_H_SYNC low for 192 cycles.
  - Frame = 840000 cycles; oVGA_V_SYNC low for 3200 cycles.
  - 307200 oReq pulses per frame.
- PIX_LAT=3, source model returns iRed=X registered through 3 ticks of delay:
  - Every tick with oVGA_BLANK=1 shows oVGA_R equal to the expected column 0..639.
  - Blanking ticks show R=0.
  - First active output is exactly 3 ticks after the first oReq of the line.
- CLK_DIV=1, tiny timing (H:1/1/4/1, V:1/1/3/1, H_POL=V_POL=1):
  - Hsync high one tick per 7.
  - Coordinate sequence (0,0)..(3,2), then wrap to (0,0) with oFrame_Start after 42 ticks.
- Enable dropped mid-active-line:
  - Next cycle oReq=0, RGB=0, syncs inactive.
  - Re-enable: first tick oFrame_Start=1, and the first request appears at (0,0) after (H_SYNC+H_BP)+(V_SYNC+V_BP)*H_TOTAL ticks.
- Resetn pulsed low asynchronously mid-frame (between edges):
  - All outputs take their reset values immediately.
  - After release, timing matches a fresh start.
- COLOR_W=8, iRGB=8'hFF constant: RGB = 8'hFF exactly when oVGA_BLANK=1, else 0.
